multi_hot_scan_encoder: RTL and testbench

Parametrised successor to the fixed 8-to-3 encoder. Accepts a WIDTH-bit vector with any number of bits set over a valid/ready handshake. Emits the index of every set bit, one per output beat, in priority order. Replaces one-hot-only encoders wherever multi-hot request vectors must be serialised into index streams, e.g. interrupt or request drain logic.

---
 rtl/encoder_pkg.sv | 36 +++
 rtl/prio_index_enc.sv | 34 +++
 rtl/multi_hot_scan_encoder.sv | 100 ++++++++++
 tb/tb_multi_hot_scan_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder family: scan state encoding plus
// width and popcount helpers reused by encoders and decoders.
package encoder_pkg;

    // Two-state scan controller: waiting for a vector, or draining one.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Widest vector the popcount helper accepts; callers zero-extend to it.
    localparam int MAX_WIDTH = 256;

    // Index width for an n-entry vector, never less than one bit.
    function automatic int index_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Number of set bits in a zero-extended vector.
    function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_index_enc.sv
// Parametrised priority encoder: reports whether any bit is set and the
// index of the winning bit (lowest or highest depending on MSB_FIRST).
module prio_index_enc
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = index_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Walk the vector so the preferred end is visited last and wins.
    always_comb begin
        any = |vec;
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/multi_hot_scan_encoder.sv
// Multi-hot scan encoder: loads a vector over valid/ready and drains the
// index of every set bit, one beat per accept, in priority order.
module multi_hot_scan_encoder
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = index_width(WIDTH),
    localparam int CNT_W    = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic             none;
    logic [CNT_W-1:0] count;
    logic             any;
    logic             pending_single;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] clear_mask;
    logic [MAX_WIDTH-1:0] in_vec_ext;

    // The index is decoded only from the pending register.
    prio_index_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec (pending),
        .any (any),
        .idx (out_idx)
    );

    // Handshake decode and beat qualifiers derived from registered state.
    always_comb begin
        out_valid      = (state == SCAN);
        pending_single = any && ((pending & (pending - WIDTH'(1))) == '0);
        out_last       = out_valid && (none || pending_single);
        out_none       = out_valid && none;
        out_count      = count;
        accept         = out_valid && out_ready;
        in_ready       = (state == IDLE) || (accept && out_last);
        load           = in_valid && in_ready;
        clear_mask     = WIDTH'(1) << out_idx;
        in_vec_ext     = MAX_WIDTH'(in_vec);
    end

    // Next-state logic; a load on the last-accept edge keeps scanning.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (accept && out_last) begin
                    state_next = load ? SCAN : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, pending bits, none flag and captured popcount.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            none    <= 1'b0;
            count   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                pending <= in_vec;
                none    <= (in_vec == '0);
                count   <= CNT_W'(popcount(in_vec_ext));
            end else if (accept) begin
                pending <= pending & ~clear_mask;
                if (out_last) begin
                    none <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_hot_scan_encoder.sv
// Directed self-checking bench; a second instance runs the MSB-first order.
module tb_multi_hot_scan_encoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_last0, out_none0;
    logic [2:0] out_idx0;
    logic [3:0] out_count0;
    logic       in_ready1, out_valid1, out_last1, out_none1;
    logic [2:0] out_idx1;
    logic [3:0] out_count1;

    int checks;
    int failures;

    multi_hot_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_vec    (in_vec),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_idx   (out_idx0),
        .out_last  (out_last0),
        .out_none  (out_none0),
        .out_count (out_count0)
    );

    multi_hot_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_vec    (in_vec),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_idx   (out_idx1),
        .out_last  (out_last1),
        .out_none  (out_none1),
        .out_count (out_count1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One step: pass an edge, then drive new inputs and let them settle.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [7:0] vec, input logic rdy);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare the LSB-first instance against an expected beat.
    task automatic checkOutput(input string tag, input logic v,
                               input logic [31:0] idx, input logic last,
                               input logic none, input logic [31:0] cnt);
        checkValue({tag, ".valid"}, 32'(out_valid0), 32'(v));
        if (v) begin
            checkValue({tag, ".idx"},   32'(out_idx0),   idx);
            checkValue({tag, ".last"},  32'(out_last0),  32'(last));
            checkValue({tag, ".none"},  32'(out_none0),  32'(none));
            checkValue({tag, ".count"}, 32'(out_count0), cnt);
        end
    endtask

    int exp_lsb [4] = '{2, 3, 4, 7};
    int exp_msb [4] = '{7, 4, 3, 2};

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;

        // Reset
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("reset.in_ready", 32'(in_ready0), 32'd1);
        checkValue("reset.valid", 32'(out_valid0), 32'd0);
        checkValue("reset.idx", 32'(out_idx0), 32'd0);
        checkValue("reset.last", 32'(out_last0), 32'd0);
        checkValue("reset.none", 32'(out_none0), 32'd0);
        checkValue("reset.count", 32'(out_count0), 32'd0);

        // One-hot sweep
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(1 << i), 1'b1);
            checkValue("onehot.in_ready", 32'(in_ready0), 32'd1);
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("onehot", 1'b1, 32'(i), 1'b1, 1'b0, 32'd1);
            checkValue("onehot.msb_idx", 32'(out_idx1), 32'(i));
        end

        // Multi-hot in both scan orders
        applyStimulus(1'b0, 1'b1, 8'b10011100, 1'b1);
        checkValue("multi.in_ready", 32'(in_ready0), 32'd1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("multi", 1'b1, 32'(exp_lsb[k]), (k == 3), 1'b0, 32'd4);
            checkValue("multi.msb_idx", 32'(out_idx1), 32'(exp_msb[k]));
            checkValue("multi.msb_last", 32'(out_last1), 32'(k == 3));
            checkValue("multi.msb_count", 32'(out_count1), 32'd4);
        end

        // Zero vector
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
        checkValue("zero.in_ready", 32'(in_ready0), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("zero", 1'b1, 32'd0, 1'b1, 1'b1, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("zero.idle_valid", 32'(out_valid0), 32'd0);
        checkValue("zero.idle_in_ready", 32'(in_ready0), 32'd1);

        // Backpressure
        applyStimulus(1'b0, 1'b1, 8'b01010000, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("bp.first", 1'b1, 32'd4, 1'b0, 1'b0, 32'd2);
        checkValue("bp.in_ready", 32'(in_ready0), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("bp.hold1", 1'b1, 32'd4, 1'b0, 1'b0, 32'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("bp.hold2", 1'b1, 32'd4, 1'b0, 1'b0, 32'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("bp.hold3", 1'b1, 32'd4, 1'b0, 1'b0, 32'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("bp.second", 1'b1, 32'd6, 1'b1, 1'b0, 32'd2);
        checkValue("bp.last_in_ready", 32'(in_ready0), 32'd1);

        // Back-to-back loads with no bubble
        applyStimulus(1'b0, 1'b1, 8'b00000011, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'b10000000, 1'b1);
        checkOutput("b2b.beat0", 1'b1, 32'd0, 1'b0, 1'b0, 32'd2);
        checkValue("b2b.beat0_in_ready", 32'(in_ready0), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'b10000000, 1'b1);
        checkOutput("b2b.beat1", 1'b1, 32'd1, 1'b1, 1'b0, 32'd2);
        checkValue("b2b.beat1_in_ready", 32'(in_ready0), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("b2b.beat7", 1'b1, 32'd7, 1'b1, 1'b0, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("b2b.idle", 32'(out_valid0), 32'd0);

        // All-ones interrupted by reset
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ff.beat0", 1'b1, 32'd0, 1'b0, 1'b0, 32'd8);
        checkValue("ff.msb_beat0", 32'(out_idx1), 32'd7);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ff.beat1", 1'b1, 32'd1, 1'b0, 1'b0, 32'd8);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ff.beat2", 1'b1, 32'd2, 1'b0, 1'b0, 32'd8);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("rst.valid", 32'(out_valid0), 32'd0);
        checkValue("rst.in_ready", 32'(in_ready0), 32'd1);
        checkValue("rst.count", 32'(out_count0), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'b00100000, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst", 1'b1, 32'd5, 1'b1, 1'b0, 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkValue("post_rst.idle", 32'(out_valid0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
